// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_unit
// Description : Instruction fetch front end. Fetches words over req/gnt/rvalid,
//               buffers them with their PCs and flushes on EX redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int          AW          = $clog2(DEPTH);
    localparam int          CW          = $clog2(DEPTH) + 1;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam logic [CW+1:0] c_DEPTH_W = (CW+2)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_discard;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];

    logic [CW+1:0] w_outstanding;
    logic          w_fire;
    logic          w_drop;
    logic          w_keep;
    logic          w_pop;
    logic [31:0]   w_target;
    logic [CW-1:0] w_discard_redir;
    logic          w_unused;

    // Issue decision uses registered occupancy only, so no input reaches mem_req.
    assign w_outstanding = {2'b00, r_count} + {2'b00, r_live} + {2'b00, r_discard};
    assign mem_req       = !reset && (w_outstanding < c_DEPTH_W);
    assign mem_addr      = r_fetch_pc;

    assign w_fire = mem_req && mem_gnt;
    assign w_drop = mem_rvalid && (r_discard != '0);
    assign w_keep = mem_rvalid && (r_discard == '0) && (r_live != '0);
    assign w_pop  = if_valid && if_ready;

    assign w_target = {redirect_pc[31:2], 2'b00};
    assign w_unused = ^redirect_pc[1:0];

    // Everything granted and not yet returned is dropped; a grant this cycle
    // still belongs to the old path.
    assign w_discard_redir = r_discard + r_live + CW'(w_fire) - CW'(w_drop | w_keep);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_VECTOR;
            r_resp_pc  <= RESET_VECTOR;
            r_count    <= '0;
            r_live     <= '0;
            r_discard  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_count    <= '0;
            r_live     <= '0;
            r_discard  <= w_discard_redir;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_keep) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wr_ptr  <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= r_count + CW'(w_keep) - CW'(w_pop);
            r_live    <= r_live + CW'(w_fire) - CW'(w_keep);
            r_discard <= r_discard - CW'(w_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && w_keep) begin
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
            r_fifo_instr[r_wr_ptr] <= mem_rdata;
        end
    end

    assign if_valid = !reset && (r_count != '0);
    assign if_pc    = if_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0000_0000;
    assign if_instr = if_valid ? r_fifo_instr[r_rd_ptr] : c_NOP;

endmodule
`default_nettype wire
